// File: rtl/uart_console_rx.sv
// Console UART receiver: 2-flop line synchronizer, 8N1 deframer and a fall-through byte FIFO.
// Break conditions raise a single frame error and are not turned into a stream of 0x00 bytes.
module uart_console_rx #(
   parameter int CLKS_PER_BIT = 174,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clk_gen,
   input  logic                        rst_n,
   input  logic                        uart_rx_i,
   output logic [7:0]                  rd_data_o,
   output logic                        rd_valid_o,
   input  logic                        rd_ready_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic                        frame_err_o,
   output logic                        overflow_o,
   input  logic                        err_clr_i
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t              state_q;
   logic                sync1_q, sync2_q;
   logic [BAUD_W-1:0]   baud_q;
   logic [2:0]          bit_q;
   logic [7:0]          shift_q;

   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                frameErr_q, frameErr_d, overflow_q, overflow_d;

   logic                stopSample, pushReq, frameErrSet;
   logic                full, popEn, pushEn;

   always_ff @(posedge clk_gen or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_rx_i;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk_gen or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!sync2_q) begin
                  state_q <= START;
                  baud_q  <= '0;
               end
            end
            START: begin
               if (baud_q == HALF_LAST) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= sync2_q ? IDLE : DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  state_q <= sync2_q ? IDLE : WAIT_IDLE;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            WAIT_IDLE: begin
               if (sync2_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   always_comb begin
      stopSample  = (state_q == STOP) && (baud_q == BAUD_LAST);
      pushReq     = stopSample && sync2_q;
      frameErrSet = stopSample && !sync2_q;
      full        = (level_q == LVL_FULL);
      popEn       = (level_q != '0) && rd_ready_i;
      pushEn      = pushReq && (!full || popEn);
      level_d     = level_q + LVL_W'(pushEn) - LVL_W'(popEn);
      wrPtr_d     = wrPtr_q + PTR_W'(pushEn);
      rdPtr_d     = rdPtr_q + PTR_W'(popEn);
      frameErr_d  = (frameErr_q && !err_clr_i) || frameErrSet;
      overflow_d  = (overflow_q && !err_clr_i) || (pushReq && full && !popEn);
   end

   always_ff @(posedge clk_gen or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         frameErr_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (pushEn) mem_q[wrPtr_q] <= shift_q;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         frameErr_q <= frameErr_d;
         overflow_q <= overflow_d;
      end
   end

   assign rd_data_o    = mem_q[rdPtr_q];
   assign rd_valid_o   = (level_q != '0);
   assign fifo_level_o = level_q;
   assign frame_err_o  = frameErr_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_console_rx.sv
// Bench for uart_console_rx: serial frames are driven bit by bit while a queue-based model
// predicts FIFO contents and sticky flags every cycle.
module tb_uart_console_rx;

   localparam int CPB      = 174;
   localparam int DEPTH    = 16;
   localparam int HALF     = CPB / 2;
   // Line fall -> two synchronizer flops -> start detect -> half bit -> 8 data bits -> stop sample.
   localparam int PUSH_LAT = 3 + HALF + 9 * CPB;

   logic       clk_gen = 1'b0;
   logic       rst_n;
   logic       uart_rx_i;
   logic [7:0] rd_data_o;
   logic       rd_valid_o;
   logic       rd_ready_i;
   logic [4:0] fifo_level_o;
   logic       frame_err_o;
   logic       overflow_o;
   logic       err_clr_i;

   int         checks = 0;
   int         failures = 0;
   longint     edgeCnt = 0;
   longint     pendEdge = -1;
   logic [7:0] pendByte = '0;
   bit         pendGood = 1'b0;
   bit         randDone = 1'b0;

   logic [7:0] modelQ[$];
   bit         mFerr, mOvf, prevValid, prevReady, prevClr;

   uart_console_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_gen     (clk_gen),
      .rst_n       (rst_n),
      .uart_rx_i   (uart_rx_i),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .fifo_level_o(fifo_level_o),
      .frame_err_o (frame_err_o),
      .overflow_o  (overflow_o),
      .err_clr_i   (err_clr_i)
   );

   always #5 clk_gen = ~clk_gen;

   initial forever begin
      @(posedge clk_gen);
      edgeCnt++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, actual, expected, edgeCnt);
      end
   endtask

   task automatic driveBit(input logic v, input int cycles);
      @(posedge clk_gen);
      #1 uart_rx_i = v;
      repeat (cycles - 1) @(posedge clk_gen);
   endtask

   task automatic lineHold(input logic v, input int bits);
      driveBit(v, bits * CPB);
   endtask

   // pulseReady raises rd_ready_i for exactly the edge on which the stop bit is sampled.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit pulseReady);
      @(posedge clk_gen);
      #1 uart_rx_i = 1'b0;
      pendByte = data;
      pendGood = stopBit;
      pendEdge = edgeCnt + PUSH_LAT;
      repeat (CPB - 1) @(posedge clk_gen);
      for (int i = 0; i < 8; i++) driveBit(data[i], CPB);
      if (pulseReady) begin
         @(posedge clk_gen);
         #1 uart_rx_i = stopBit;
         repeat (HALF + 2) @(posedge clk_gen);
         #1 rd_ready_i = 1'b1;
         @(posedge clk_gen);
         #1 rd_ready_i = 1'b0;
         repeat (CPB - HALF - 4) @(posedge clk_gen);
      end else begin
         driveBit(stopBit, CPB);
      end
   endtask

   task automatic drainOne(input logic [7:0] expected);
      @(negedge clk_gen);
      checkOutput("drain_data", rd_data_o, expected);
      @(posedge clk_gen);
      #1 rd_ready_i = 1'b1;
      @(posedge clk_gen);
      #1 rd_ready_i = 1'b0;
   endtask

   task automatic pulseClr();
      @(posedge clk_gen);
      #1 err_clr_i = 1'b1;
      @(posedge clk_gen);
      #1 err_clr_i = 1'b0;
   endtask

   // Model: each negedge applies the previous edge's pop, clear and scheduled push, then compares.
   initial begin
      bit doPop;
      forever begin
         @(negedge clk_gen);
         if (!rst_n) begin
            modelQ.delete();
            mFerr = 1'b0;
            mOvf  = 1'b0;
         end else begin
            doPop = prevValid && prevReady;
            if (prevClr) begin
               mFerr = 1'b0;
               mOvf  = 1'b0;
            end
            if (doPop) void'(modelQ.pop_front());
            if (pendEdge == edgeCnt) begin
               if (!pendGood) mFerr = 1'b1;
               else if (modelQ.size() < DEPTH) modelQ.push_back(pendByte);
               else mOvf = 1'b1;
            end
         end
         checkOutput("level", fifo_level_o, modelQ.size());
         checkOutput("valid", rd_valid_o, modelQ.size() != 0);
         if (modelQ.size() != 0) checkOutput("head", rd_data_o, modelQ[0]);
         checkOutput("frame_err", frame_err_o, mFerr);
         checkOutput("overflow", overflow_o, mOvf);
         prevValid = (modelQ.size() != 0);
         prevReady = rd_ready_i;
         prevClr   = err_clr_i;
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      uart_rx_i  = 1'b1;
      rd_ready_i = 1'b0;
      err_clr_i  = 1'b0;
      repeat (3) @(posedge clk_gen);
      @(negedge clk_gen);
      checkOutput("rst_level", fifo_level_o, 0);
      checkOutput("rst_valid", rd_valid_o, 0);
      checkOutput("rst_data", rd_data_o, 8'h00);
      checkOutput("rst_flags", {frame_err_o, overflow_o}, 2'b00);
      @(posedge clk_gen);
      #1 rst_n = 1'b1;
      lineHold(1'b1, 2);

      applyStimulus(8'hA5, 1'b1, 1'b0);
      lineHold(1'b1, 1);
      @(negedge clk_gen);
      checkOutput("a5_valid", rd_valid_o, 1);
      checkOutput("a5_data", rd_data_o, 8'hA5);
      checkOutput("a5_level", fifo_level_o, 1);
      checkOutput("a5_flags", {frame_err_o, overflow_o}, 2'b00);
      drainOne(8'hA5);

      for (int i = 0; i <= 16; i++) begin
         applyStimulus(8'(i), 1'b1, 1'b0);
         lineHold(1'b1, 1);
      end
      @(negedge clk_gen);
      checkOutput("full_level", fifo_level_o, 16);
      checkOutput("full_ovf", overflow_o, 1);
      checkOutput("full_head", rd_data_o, 8'h00);
      pulseClr();
      @(negedge clk_gen);
      checkOutput("clr_ovf", overflow_o, 0);

      applyStimulus(8'h11, 1'b1, 1'b1);
      lineHold(1'b1, 1);
      @(negedge clk_gen);
      checkOutput("pp_level", fifo_level_o, 16);
      checkOutput("pp_ovf", overflow_o, 0);
      checkOutput("pp_head", rd_data_o, 8'h01);
      for (int i = 1; i < 16; i++) drainOne(8'(i));
      drainOne(8'h11);
      @(negedge clk_gen);
      checkOutput("drained_level", fifo_level_o, 0);

      @(posedge clk_gen);
      #1 uart_rx_i = 1'b0;
      repeat (CPB / 4) @(posedge clk_gen);
      #1 uart_rx_i = 1'b1;
      lineHold(1'b1, 2);
      @(negedge clk_gen);
      checkOutput("glitch_level", fifo_level_o, 0);
      checkOutput("glitch_flags", {frame_err_o, overflow_o}, 2'b00);

      applyStimulus(8'h3C, 1'b0, 1'b0);
      lineHold(1'b0, 20);
      @(negedge clk_gen);
      checkOutput("brk_ferr", frame_err_o, 1);
      checkOutput("brk_level", fifo_level_o, 0);
      lineHold(1'b1, 2);
      applyStimulus(8'h55, 1'b1, 1'b0);
      lineHold(1'b1, 1);
      @(negedge clk_gen);
      checkOutput("after_brk_level", fifo_level_o, 1);
      checkOutput("after_brk_data", rd_data_o, 8'h55);

      // Abort a 0x6C frame in the middle of bit 4.
      driveBit(1'b0, CPB);
      for (int i = 0; i < 4; i++) driveBit(i == 2 || i == 3, CPB);
      driveBit(1'b0, HALF);
      #1 rst_n = 1'b0;
      uart_rx_i = 1'b1;
      @(negedge clk_gen);
      checkOutput("midrst_level", fifo_level_o, 0);
      checkOutput("midrst_data", rd_data_o, 8'h00);
      checkOutput("midrst_flags", {frame_err_o, overflow_o}, 2'b00);
      repeat (5) @(posedge clk_gen);
      #1 rst_n = 1'b1;
      lineHold(1'b1, 2);
      applyStimulus(8'h81, 1'b1, 1'b0);
      lineHold(1'b1, 1);
      @(negedge clk_gen);
      checkOutput("post_rst_level", fifo_level_o, 1);
      checkOutput("post_rst_data", rd_data_o, 8'h81);

      fork
         begin
            for (int k = 0; k < 8; k++) begin
               applyStimulus(8'($urandom), $urandom_range(0, 5) != 0, 1'b0);
               lineHold(1'b1, $urandom_range(1, 3));
            end
            randDone = 1'b1;
         end
         begin
            while (!randDone) begin
               @(posedge clk_gen);
               #1 rd_ready_i = 1'($urandom_range(0, 1));
               err_clr_i = ($urandom_range(0, 63) == 0);
            end
            rd_ready_i = 1'b0;
            err_clr_i  = 1'b0;
         end
      join

      @(posedge clk_gen);
      #1 rd_ready_i = 1'b1;
      repeat (30) @(posedge clk_gen);
      #1 rd_ready_i = 1'b0;
      @(negedge clk_gen);
      checkOutput("final_level", fifo_level_o, 0);
      checkOutput("final_valid", rd_valid_o, 0);

      @(negedge clk_gen);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
